// File: rtl/clock_set_controller_pkg.sv
// clock_set_pkg: FSM state encoding, digit indices and the digit-advance helper for clock_set_controller.
package clock_set_pkg;
  typedef enum logic [1:0] {RUN, SET, INC, REPEAT} state_t;
  localparam int SEC_U = 0;
  localparam int SEC_T = 1;
  localparam int MIN_U = 2;
  localparam int MIN_T = 3;
  localparam int HR_U = 4;
  localparam int HR_T = 5;
  function automatic logic [2:0] next_idx(input logic [2:0] idx, input int n);
    return (int'(idx) == n - 1) ? 3'd0 : idx + 3'd1;
  endfunction
endpackage

// File: rtl/clock_set_controller_if.sv
// clock_set_controller_if: button pins in, set_time/slt/sel_idx/active out toward the counter chain.
interface clock_set_controller_if #(parameter int NUM_DIGITS = 6);
  logic btn_mode, btn_next, btn_inc, set_time, active;
  logic [NUM_DIGITS-1:0] slt;
  logic [2:0] sel_idx;
  modport master(output btn_mode, btn_next, btn_inc, input set_time, slt, sel_idx, active);
  modport slave(input btn_mode, btn_next, btn_inc, output set_time, slt, sel_idx, active);
endinterface

// File: rtl/clock_set_controller_btn_conditioner.sv
// btn_conditioner: 2-flop sync, debounce over DEBOUNCE_CYCLES equal samples, one-cycle rising-edge press.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clkmain,
  input  logic clear,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, done;
  logic [CW-1:0] cnt;
  assign done = s2 != level && cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clkmain or posedge clear)
    if (clear) begin
      {s1, s2, level, press} <= '0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      cnt <= (s2 == level || done) ? '0 : cnt + 1'b1;
      level <= done ? s2 : level;
      press <= done & s2;
    end
endmodule

// File: rtl/clock_set_controller.sv
// clock_set_controller: time-setting sequencer for the digit counter chain.
// Define AUTOREPEAT_EN to build the held-inc auto-repeat (REPEAT state).
module clock_set_controller
  import clock_set_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 60,
  parameter int REPEAT_DELAY = 3,
  parameter int REPEAT_PERIOD = 1
) (
  input logic clkmain,
  input logic clear,
  clock_set_controller_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t state, nxt;
  logic [2:0] sel, sel_nxt, adv;
  logic [TW-1:0] tmo;
  logic mode_ev, next_ev, inc_ev, inc_lvl, any_ev;
  logic [1:0] unused_lvl;
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clkmain(clkmain), .clear(clear), .raw(bus.btn_mode), .level(unused_lvl[0]), .press(mode_ev));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clkmain(clkmain), .clear(clear), .raw(bus.btn_next), .level(unused_lvl[1]), .press(next_ev));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clkmain(clkmain), .clear(clear), .raw(bus.btn_inc), .level(inc_lvl), .press(inc_ev));
  assign any_ev = mode_ev | next_ev | inc_ev;
  assign adv = next_idx(sel, NUM_DIGITS);
`ifdef AUTOREPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  logic [RW-1:0] rpt;
  // Loaded with the first delay while idle in SET; an INC reached from REPEAT keeps the period value.
  always_ff @(posedge clkmain or posedge clear)
    if (clear) rpt <= '0;
    else if (state == SET) rpt <= RW'(REPEAT_DELAY);
    else if (state == REPEAT) rpt <= rpt == RW'(1) ? RW'(REPEAT_PERIOD) : rpt - 1'b1;
`else
  localparam int unused_rpt = REPEAT_DELAY + REPEAT_PERIOD;
  logic unused_inc;
  assign unused_inc = inc_lvl;
`endif
  always_comb begin
    nxt = state;
    sel_nxt = sel;
    case (state)
      RUN: begin
        nxt = mode_ev ? SET : RUN;
        sel_nxt = mode_ev ? 3'd0 : sel;
      end
      SET: begin
        nxt = mode_ev ? RUN : next_ev ? SET : inc_ev ? INC : tmo == TW'(TIMEOUT_CYCLES - 1) ? RUN : SET;
        sel_nxt = !mode_ev && next_ev ? adv : sel;
      end
`ifdef AUTOREPEAT_EN
      INC: nxt = inc_lvl ? REPEAT : SET;
      REPEAT: begin
        nxt = mode_ev ? RUN : (next_ev || !inc_lvl) ? SET : rpt == RW'(1) ? INC : REPEAT;
        sel_nxt = !mode_ev && next_ev ? adv : sel;
      end
`else
      INC: nxt = SET;
`endif
      default: nxt = RUN;
    endcase
  end
  always_ff @(posedge clkmain or posedge clear)
    if (clear) begin
      state <= RUN;
      sel <= '0;
      tmo <= '0;
    end else begin
      state <= nxt;
      sel <= sel_nxt;
      tmo <= (any_ev || state == RUN) ? '0 : state == SET ? tmo + 1'b1 : tmo;
    end
  // Outputs are registered from the next state so they change on the edge that acts on an event.
  always_ff @(posedge clkmain or posedge clear)
    if (clear) begin
      bus.set_time <= 1'b0;
      bus.active <= 1'b0;
      bus.slt <= '0;
    end else begin
      bus.set_time <= nxt != RUN;
      bus.active <= nxt != RUN;
      bus.slt <= nxt == INC ? NUM_DIGITS'(1) << sel_nxt : '0;
    end
  assign bus.sel_idx = sel;
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: vector table, hand-written corner sequences and random stimulus vs a cycle reference model.
module tb_clock_set_controller;
  import clock_set_pkg::*;
  localparam int N = 6, D = 4, T = 60, RD = 3, RP = 1;
`ifdef AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic clkmain = 1'b0;
  logic clear = 1'b1;
  logic [2:0] raw = 3'b000;
  always #5 clkmain = ~clkmain;
  clock_set_controller_if #(.NUM_DIGITS(N)) bus ();
  assign {bus.btn_inc, bus.btn_next, bus.btn_mode} = raw;
  clock_set_controller #(.NUM_DIGITS(N), .DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (.clkmain(clkmain), .clear(clear), .bus(bus));

  int total = 0, bad = 0;
  // Model: raw sample history per button, in_set flag, selected digit, idle count,
  // and burst = cycles since the first pulse of the current inc hold (-1: none).
  bit hist[3][$];
  bit m_lvl[3], m_prs[3];
  bit m_set;
  int m_sel, m_idle, m_burst;

  function automatic bit pulse_at(input int k);
    return k == 0 || (AR && k > RD && (k - RD - 1) % (RP + 1) == 0);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      hist[b].delete();
      repeat (D + 2) hist[b].push_back(1'b0);
      m_lvl[b] = 1'b0;
      m_prs[b] = 1'b0;
    end
    m_set = 1'b0; m_sel = 0; m_idle = 0; m_burst = -1;
  endtask

  task automatic model_edge();
    bit em, en, ei, v, eq;
    em = m_prs[0]; en = m_prs[1]; ei = m_prs[2];
    if (!m_set) begin
      if (em) begin m_set = 1'b1; m_sel = 0; m_idle = 0; end
    end else if (m_burst < 0) begin
      m_idle = (em || en || ei) ? 0 : m_idle + 1;
      if (em) m_set = 1'b0;
      else if (en) m_sel = (m_sel + 1) % N;
      else if (ei) m_burst = 0;
      else if (m_idle == T) m_set = 1'b0;
    end else if (pulse_at(m_burst)) m_burst = (AR && m_lvl[2]) ? m_burst + 1 : -1;
    else if (em) begin m_set = 1'b0; m_burst = -1; end
    else if (en) begin m_sel = (m_sel + 1) % N; m_burst = -1; end
    else m_burst = m_lvl[2] ? m_burst + 1 : -1;
    for (int b = 0; b < 3; b++) begin
      hist[b].push_back(raw[b]);
      void'(hist[b].pop_front());
      v = hist[b][0];
      eq = 1'b1;
      for (int i = 1; i < D; i++) if (hist[b][i] != v) eq = 1'b0;
      m_prs[b] = 1'b0;
      if (eq && v != m_lvl[b]) begin m_lvl[b] = v; m_prs[b] = v; end
    end
  endtask

  task automatic check(input string name);
    logic [N-1:0] e_slt;
    e_slt = (m_set && m_burst >= 0 && pulse_at(m_burst)) ? N'(1) << m_sel : '0;
    total++;
    if ({bus.set_time, bus.active, bus.sel_idx, bus.slt} !== {m_set, m_set, 3'(m_sel), e_slt}) begin
      bad++;
      $display("FAIL %s t=%0t got set=%b act=%b sel=%0d slt=%b want set=%b sel=%0d slt=%b", name, $time,
        bus.set_time, bus.active, bus.sel_idx, bus.slt, m_set, m_sel, e_slt);
    end
  endtask

  task automatic tick(input logic [2:0] r);
    raw = r;
    @(posedge clkmain);
    model_edge();
    @(negedge clkmain);
    check("model");
  endtask

  task automatic press(input logic [2:0] r);
    for (int c = 0; c < 16; c++) tick(c < 4 ? r : 3'b000);
  endtask

  typedef struct {
    logic [2:0] btn;
    bit exp_set;
    int exp_sel;
    int exp_pulses;
    logic [N-1:0] exp_slt;
    string name;
  } vec_t;
  vec_t tbl[15];
  int exp_off[5] = '{0, 4, 6, 8, 10};

  initial begin
    int pulses, f, rise, fall, ne;
    logic [N-1:0] last;
    int offs[$];
    bit found;
    tbl[0] = '{3'b001, 1'b1, 0, 0, '0, "mode_enter"};
    for (int i = 1; i <= 6; i++) tbl[i] = '{3'b010, 1'b1, i % N, 0, '0, "next_wrap"};
    tbl[7] = '{3'b100, 1'b1, 0, 1, N'(1) << SEC_U, "inc_sec_u"};
    tbl[8] = '{3'b010, 1'b1, 1, 0, '0, "next_one"};
    tbl[9] = '{3'b100, 1'b1, 1, 1, N'(1) << SEC_T, "inc_sec_t"};
    tbl[10] = '{3'b101, 1'b0, 1, 0, '0, "mode_over_inc"};
    tbl[11] = '{3'b010, 1'b0, 1, 0, '0, "next_in_run"};
    tbl[12] = '{3'b100, 1'b0, 1, 0, '0, "inc_in_run"};
    tbl[13] = '{3'b001, 1'b1, 0, 0, '0, "reenter_zero"};
    tbl[14] = '{3'b001, 1'b0, 0, 0, '0, "mode_leave"};
    model_reset();
    repeat (2) @(negedge clkmain);
    check("reset_state");
    clear = 1'b0;
    for (int i = 0; i < 15; i++) begin
      pulses = 0;
      last = '0;
      for (int c = 0; c < 16; c++) begin
        tick(c < 4 ? tbl[i].btn : 3'b000);
        if (bus.slt != 0) begin pulses++; last = bus.slt; end
      end
      total++;
      if (bus.set_time !== tbl[i].exp_set || bus.sel_idx !== 3'(tbl[i].exp_sel) ||
          pulses != tbl[i].exp_pulses || last !== tbl[i].exp_slt) begin
        bad++;
        $display("FAIL %s[%0d] got set=%b sel=%0d pulses=%0d slt=%b want set=%b sel=%0d pulses=%0d slt=%b",
          tbl[i].name, i, bus.set_time, bus.sel_idx, pulses, last,
          tbl[i].exp_set, tbl[i].exp_sel, tbl[i].exp_pulses, tbl[i].exp_slt);
      end
    end
    // Held inc: debounced level stays high long enough for a pulse at +10 but not +12.
    press(3'b001);
    f = -1;
    for (int c = 0; c < 30; c++) begin
      tick(c < 11 ? 3'b100 : 3'b000);
      if (bus.slt != 0) begin
        if (f < 0) f = c;
        offs.push_back(c - f);
      end
    end
    ne = AR ? 5 : 1;
    total++;
    if (offs.size() != ne) begin
      bad++;
      $display("FAIL repeat_count got=%0d want=%0d", offs.size(), ne);
    end
    for (int i = 0; i < ne && i < offs.size(); i++) begin
      total++;
      if (offs[i] != exp_off[i]) begin
        bad++;
        $display("FAIL repeat_offset[%0d] got=%0d want=%0d", i, offs[i], exp_off[i]);
      end
    end
    press(3'b001);
    // Timeout with a single-cycle glitch on next inside the idle window.
    rise = -1;
    fall = -1;
    for (int c = 0; c < 200; c++) begin
      tick(c < 4 ? 3'b001 : c == 20 ? 3'b010 : 3'b000);
      if (bus.set_time && rise < 0) rise = c;
      if (!bus.set_time && rise >= 0 && fall < 0) fall = c;
    end
    total++;
    if (rise < 0 || fall < 0 || fall - rise != T || bus.sel_idx !== 3'd0) begin
      bad++;
      $display("FAIL timeout got rise=%0d fall=%0d high=%0d sel=%0d want high=%0d sel=0",
        rise, fall, fall - rise, bus.sel_idx, T);
    end
    // Async clear while slt is high on digit 1.
    press(3'b001);
    press(3'b010);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick(3'b100);
      found = bus.slt != 0;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reset_wait got slt=0 within 20 cycles want a pulse");
    end
    clear = 1'b1;
    #1;
    total++;
    if ({bus.set_time, bus.active, bus.slt, bus.sel_idx} !== '0) begin
      bad++;
      $display("FAIL async_clear got set=%b act=%b slt=%b sel=%0d want all zero",
        bus.set_time, bus.active, bus.slt, bus.sel_idx);
    end
    raw = 3'b000;
    @(negedge clkmain);
    model_reset();
    check("held_clear");
    clear = 1'b0;
    press(3'b010);
    press(3'b001);
    press(3'b001);
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 70)) tick(3'b000);
      end else begin
        automatic logic [2:0] r = {1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0)};
        repeat ($urandom_range(1, 14)) tick(r);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
